// File: rtl/knn_pkg.sv
// rtl/knn_pkg.sv - shared state encoding, error bit indices and beat arithmetic for the KNN sequencer
package knn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN,
        ST_COMPLETE
    } knn_state_t;

    localparam int ERR_ZERO_SAMPLES = 0;
    localparam int ERR_TLAST        = 1;
    localparam int ERR_TIMEOUT      = 2;

    function automatic int BEATS(input int dimensions, input int num_ch);
        return dimensions / num_ch;
    endfunction

endpackage

// File: rtl/knn_stream_sequencer_if.sv
// rtl/knn_stream_sequencer_if.sv - stream handshake bundle with master/slave views
interface knn_stream_sequencer_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/knn_result_fifo.sv
// rtl/knn_result_fifo.sv - synchronous result FIFO; reads return 0 while empty
module knn_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can accept a write in the same cycle its head is read out.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/knn_stream_sequencer.sv
// rtl/knn_stream_sequencer.sv - sequences one KNN run: streams training data into the core, buffers K results
// Optional DRAIN watchdog enabled by KNN_SEQ_TIMEOUT_EN.
module knn_stream_sequencer
    import knn_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DIMENSIONS  = 32,
    parameter int NUM_CH      = 1,
    parameter int K           = 1,
    parameter int SAMPLE_W    = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [SAMPLE_W-1:0]          num_samples,
    output logic                         busy,
    output logic                         irq,
    output logic [2:0]                   err,
    knn_stream_sequencer_if.slave        s_axis,
    output logic                         core_wr_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] core_data,
    output logic                         core_done,
    input  logic                         core_out_valid,
    input  logic [31:0]                  core_name,
    input  logic [DATA_WIDTH-1:0]        core_value,
    knn_stream_sequencer_if.master       m_axis
);
    localparam int NBEATS = BEATS(DIMENSIONS, NUM_CH);
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int RW     = $clog2(K + 1);

    knn_state_t                  state_q, state_d;
    logic [BW-1:0]               beat_cnt;
    logic [SAMPLE_W-1:0]         vec_cnt;
    logic [SAMPLE_W-1:0]         samples_q;
    logic [RW-1:0]               res_cnt;
    logic [RW-1:0]               pop_cnt;
    logic [2:0]                  err_q;
    logic                        irq_q;
    logic                        wr_en_q;
    logic                        done_q;
    logic [NUM_CH*DATA_WIDTH-1:0] data_q;

    logic s_hs, final_beat, start_ok, zero_start, timeout;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty, in_run;
    logic [31+DATA_WIDTH:0] fifo_rdata;

    assign s_hs       = s_axis.tvalid && s_axis.tready;
    assign final_beat = (beat_cnt == BW'(NBEATS-1)) && (vec_cnt == samples_q - 1'b1);
    assign start_ok   = (state_q == ST_IDLE) && start && (num_samples != '0);
    assign zero_start = (state_q == ST_IDLE) && start && (num_samples == '0);
    assign in_run     = (state_q == ST_LOAD) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
    // The core cannot be stalled, so results are accepted from LOAD onward, never beyond K.
    assign fifo_push  = core_out_valid && in_run && (res_cnt != RW'(K)) && (!fifo_full || fifo_pop);
    assign fifo_pop   = !fifo_empty && m_axis.tready;

    knn_result_fifo #(
        .WIDTH(32 + DATA_WIDTH),
        .DEPTH(K)
    ) u_fifo (
        .clk   (clk),
        .resetn(resetn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({core_name, core_value}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef KNN_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                   wd_cnt <= '0;
        else if (state_q != ST_DRAIN || core_out_valid) wd_cnt <= '0;
        else                                           wd_cnt <= wd_cnt + 1'b1;
    end

    assign timeout = (state_q == ST_DRAIN) && !core_out_valid && (wd_cnt == WW'(TIMEOUT_CYC-1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start_ok) state_d = ST_LOAD;
            ST_LOAD:     if (s_hs && final_beat) state_d = ST_FLUSH;
            ST_FLUSH:    state_d = ST_DRAIN;
            ST_DRAIN:    if (res_cnt == RW'(K) || timeout) state_d = ST_COMPLETE;
            ST_COMPLETE: if (fifo_empty) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            beat_cnt  <= '0;
            vec_cnt   <= '0;
            samples_q <= '0;
            res_cnt   <= '0;
            pop_cnt   <= '0;
            err_q     <= '0;
            irq_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= s_hs;
            done_q  <= (state_q == ST_FLUSH);
            irq_q   <= zero_start || ((state_q == ST_COMPLETE) && fifo_empty);
            if (s_hs) data_q <= s_axis.tdata;

            if (start_ok) begin
                samples_q <= num_samples;
                beat_cnt  <= '0;
                vec_cnt   <= '0;
                res_cnt   <= '0;
                pop_cnt   <= '0;
                err_q     <= '0;
            end else if (zero_start) begin
                err_q <= 3'(1 << ERR_ZERO_SAMPLES);
            end

            if (s_hs) begin
                beat_cnt <= (beat_cnt == BW'(NBEATS-1)) ? '0 : beat_cnt + 1'b1;
                if (beat_cnt == BW'(NBEATS-1)) vec_cnt <= vec_cnt + 1'b1;
                if (s_axis.tlast != final_beat) err_q[ERR_TLAST] <= 1'b1;
            end

            if (fifo_push) res_cnt <= res_cnt + 1'b1;
            if (fifo_pop)  pop_cnt <= (pop_cnt == RW'(K-1)) ? '0 : pop_cnt + 1'b1;
            if (timeout)   err_q[ERR_TIMEOUT] <= 1'b1;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign irq           = irq_q;
    assign err           = err_q;
    assign core_wr_en    = wr_en_q;
    assign core_data     = data_q;
    assign core_done     = done_q;
    assign s_axis.tready = (state_q == ST_LOAD);
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = fifo_rdata;
    assign m_axis.tlast  = !fifo_empty && (pop_cnt == RW'(K-1));

endmodule
